ysyx_24100012_pipe_reg: RTL and testbench
=========================================

# ysyx_24100012_pipe_reg

Parametrised pipeline stage register with a valid/ready handshake on both sides, synchronous flush and an optional skid entry. It is the next step beyond the plain write-enabled register, with two differences. It carries its own valid bit, and it cuts the combinational ready path between NPC pipeline stages (IFU→IDU→EXU→LSU→WBU). Each stage boundary instantiates one, with `WIDTH` sized to that boundary's bundle.

## Interface
- `WIDTH`, default 32: payload width in bits.
- `RESET_VAL`, default 0: value of `out_data` after reset.
- `SKID`, default 1: selects the buffering mode.
  - 1: two entries (main + skid); `in_ready` depends only on registered state.
  - 0: one entry; `in_ready` is combinational from `out_ready`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: synchronous pipeline flush; discards all held entries.
- `in_valid` in 1: upstream payload valid.
- `in_ready` out 1: stage can accept a payload this cycle.
- `in_data` in `WIDTH`: upstream payload.
- `out_valid` out 1: `out_data` holds a valid entry.
- `out_ready` in 1: downstream accepts the entry this cycle.
- `out_data` out `WIDTH`: head entry; always the main register.
- `level` out 2: occupancy, range 0..2 (max 1 when `SKID`=0).

## Operation
- Transfer rules:
  - in-fire = `in_valid & in_ready`; out-fire = `out_valid & out_ready`.
  - Both fires are evaluated at the same rising edge.
- Occupancy states: EMPTY (`level`=0), ONE (1), FULL (2; `SKID`=1 only).
- `out_valid` = (state != EMPTY).
- `in_ready`:
  - `SKID`=1: `in_ready` = (state != FULL).
  - `SKID`=0: `in_ready` = !`out_valid` | `out_ready`.
  - Forced 0 while `rst` is high (both modes).
- Transitions (`SKID`=1):
  - EMPTY, in-fire → ONE; main <= `in_data`.
  - ONE, in-fire & out-fire → ONE; main <= `in_data`.
  - ONE, in-fire only → FULL; skid <= `in_data`; main unchanged.
  - ONE, out-fire only → EMPTY.
  - FULL, out-fire → ONE; main <= skid. No in-fire is possible in FULL.
  - No fire → state and data held.
- Transitions (`SKID`=0): EMPTY/ONE only.
  - In-fire → ONE; main <= `in_data` (with or without a simultaneous out-fire).
  - Out-fire without in-fire → EMPTY.
- Ordering is strict FIFO: the skid entry is never presented before the main entry.
- Data registers:
  - Written only on the events listed above.
  - `out_data` holds its last value when EMPTY.
  - No reset of the skid register beyond `RESET_VAL`.
- Priority: `rst` > `flush` > normal operation.
- Flush cycle:
  - State → EMPTY at the edge.
  - Data registers unchanged.
  - A simultaneous out-fire counts as consumed downstream; a simultaneous in-fire is dropped.
  - `in_ready`/`out_valid` during the flush cycle still follow the current state.

## Timing
- Reset (edge with `rst`=1): `out_valid`=0, `level`=0, `out_data`=`RESET_VAL`, skid=`RESET_VAL`, `in_ready`=0 while `rst` is high.
  - After `rst` deasserts: `in_ready`=1.
- Latency: in-fire at edge N puts the payload on `out_data` with `out_valid`=1 in the cycle after edge N; there is no bypass of `in_data` to `out_data`.
- Throughput: one payload/cycle with `out_ready` held at 1, in both modes.
- `SKID`=1 backpressure:
  - `out_ready` dropping absorbs one extra payload into skid.
  - `in_ready` falls one cycle later, with no loss.
- No combinational path from `out_ready` or `in_valid` to `in_ready` when `SKID`=1. `SKID`=0 has the path `out_ready`→`in_ready`.
- Reset or flush mid-operation: the occupancy of FULL, ONE or partial transfers is discarded at that edge; the first acceptance is possible in the next cycle.

## Test plan
- **Reset.** `rst` for 2 cycles with `RESET_VAL`=0x5A → `out_valid`=0, `level`=0, `out_data`=0x5A, `in_ready`=0 during reset and 1 after.
- **Streaming, `SKID`=1.** Stream 0x1,0x2,0x3 with `out_ready`=1 → `out_data` shows 0x1,0x2,0x3 on consecutive cycles, each one cycle after its in-fire; `level` stays 1.
- **Backpressure, `SKID`=1.**
  - Stimulus: `out_ready`=0 while sending 0xA then 0xB.
  - Required: `level`=2, `in_ready`=0, `out_data`=0xA.
  - Then `out_ready`=1 for 2 cycles → 0xA then 0xB emerge in order and `level` returns to 0.
- **Flush.**
  - Stimulus: `flush` asserted in FULL (0xA, 0xB) while `in_valid`=1 with 0xC.
  - Required: next cycle `out_valid`=0, `level`=0; 0xC never appears; a later 0xD is delivered normally.
- **`SKID`=0 pass-through.** With `out_valid`=1, `out_ready`=1 and `in_valid`=1 (0x7) in the same cycle → `in_ready`=1 and the next cycle `out_data`=0x7. With `out_ready`=0 → `in_ready`=0.
- **Simultaneous transfer in ONE, `SKID`=1.** In-fire and out-fire in the same cycle → `level` stays 1 and the new payload replaces the head.

Source files
------------

// File: rtl/ysyx_24100012_pipe_reg.sv
// Pipeline stage register with valid/ready on both sides, synchronous flush
// and an optional skid entry that decouples in_ready from out_ready.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_EMPTY | nothing held, out_valid low, out_data keeps last value
//   ST_ONE   | main register holds the head entry
//   ST_FULL  | main holds the head, skid holds the next entry (SKID=1)
module ysyx_24100012_pipe_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign level     = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // With the skid entry, in_ready looks only at registered state; without it
  // the stage can refill in the same cycle the head leaves.
  generate
    if (SKID) begin : g_skid_ready
      assign in_ready = !rst && (state_q != ST_FULL);
    end else begin : g_pass_ready
      assign in_ready = !rst && (!out_valid || out_ready);
    end
  endgenerate

  // Next-state and data-register update; flush empties without touching data.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            if (SKID) begin
              state_d = ST_FULL;
              skid_d  = in_data;
            end else begin
              main_d = in_data;
            end
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24100012_pipe_reg.sv
// Bench for ysyx_24100012_pipe_reg: one skid instance and one pass-through
// instance share the stimulus; both are compared every cycle to a queue model.
module tb_ysyx_24100012_pipe_reg;

  localparam logic [31:0] RV_A = 32'h5A;
  localparam logic [31:0] RV_B = 32'hC3;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_data, b_out_data;
  logic [1:0]  a_level, b_level;

  int checks = 0;
  int errors = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] main_a, main_b;

  always #5 clk = ~clk;

  ysyx_24100012_pipe_reg #(.WIDTH(32), .RESET_VAL(RV_A), .SKID(1'b1)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .level(a_level)
  );

  ysyx_24100012_pipe_reg #(.WIDTH(32), .RESET_VAL(RV_B), .SKID(1'b0)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .level(b_level)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_lvl;
  } vec_t;

  vec_t vt[25];

  function automatic vec_t mk(input logic r, input logic f, input logic iv,
                              input logic [31:0] id, input logic ordy,
                              input logic ir, input logic ov,
                              input logic [31:0] od, input logic [1:0] lvl);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ir = ir; v.e_ov = ov; v.e_od = od; v.e_lvl = lvl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare both DUTs to the queue model at the negedge, then advance the model
  // to what the coming rising edge should produce.
  task automatic tick();
    logic er_a, er_b, ev_a, ev_b;
    @(negedge clk);
    ev_a = (qa.size() > 0);
    ev_b = (qb.size() > 0);
    er_a = !rst && (qa.size() < 2);
    er_b = !rst && (qb.size() == 0 || out_ready);
    chk("a_in_ready", a_in_ready, er_a);
    chk("a_out_valid", a_out_valid, ev_a);
    chk("a_out_data", a_out_data, ev_a ? qa[0] : main_a);
    chk("a_level", a_level, qa.size());
    chk("b_in_ready", b_in_ready, er_b);
    chk("b_out_valid", b_out_valid, ev_b);
    chk("b_out_data", b_out_data, ev_b ? qb[0] : main_b);
    chk("b_level", b_level, qb.size());
    if (rst) begin
      qa.delete(); qb.delete();
      main_a = RV_A; main_b = RV_B;
    end else if (flush) begin
      qa.delete(); qb.delete();
    end else begin
      if (ev_a && out_ready) void'(qa.pop_front());
      if (in_valid && er_a) qa.push_back(in_data);
      if (ev_b && out_ready) void'(qb.pop_front());
      if (in_valid && er_b) qb.push_back(in_data);
    end
    if (qa.size() > 0) main_a = qa[0];
    if (qb.size() > 0) main_b = qb[0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    chk("in_ready_in_reset_a", a_in_ready, 1'b0);
    chk("in_ready_in_reset_b", b_in_ready, 1'b0);
    @(posedge clk);
    #1;
    main_a = RV_A; main_b = RV_B;

    //           rst  fl  iv  id      ordy ir  ov  od      lvl
    vt[0]  = mk(1'b1,1'b0,1'b0,32'h00,1'b0,1'b0,1'b0,32'h5A,2'd0);
    vt[1]  = mk(1'b0,1'b0,1'b1,32'h01,1'b1,1'b1,1'b0,32'h5A,2'd0);
    vt[2]  = mk(1'b0,1'b0,1'b1,32'h02,1'b1,1'b1,1'b1,32'h01,2'd1);
    vt[3]  = mk(1'b0,1'b0,1'b1,32'h03,1'b1,1'b1,1'b1,32'h02,2'd1);
    vt[4]  = mk(1'b0,1'b0,1'b0,32'h00,1'b1,1'b1,1'b1,32'h03,2'd1);
    vt[5]  = mk(1'b0,1'b0,1'b1,32'h0A,1'b0,1'b1,1'b0,32'h03,2'd0);
    vt[6]  = mk(1'b0,1'b0,1'b1,32'h0B,1'b0,1'b1,1'b1,32'h0A,2'd1);
    vt[7]  = mk(1'b0,1'b0,1'b1,32'h0C,1'b0,1'b0,1'b1,32'h0A,2'd2);
    vt[8]  = mk(1'b0,1'b0,1'b0,32'h00,1'b1,1'b0,1'b1,32'h0A,2'd2);
    vt[9]  = mk(1'b0,1'b0,1'b0,32'h00,1'b1,1'b1,1'b1,32'h0B,2'd1);
    vt[10] = mk(1'b0,1'b0,1'b0,32'h00,1'b0,1'b1,1'b0,32'h0B,2'd0);
    vt[11] = mk(1'b0,1'b0,1'b1,32'h0A,1'b0,1'b1,1'b0,32'h0B,2'd0);
    vt[12] = mk(1'b0,1'b0,1'b1,32'h0B,1'b0,1'b1,1'b1,32'h0A,2'd1);
    vt[13] = mk(1'b0,1'b1,1'b1,32'h0C,1'b0,1'b0,1'b1,32'h0A,2'd2);
    vt[14] = mk(1'b0,1'b0,1'b1,32'h0D,1'b0,1'b1,1'b0,32'h0A,2'd0);
    vt[15] = mk(1'b0,1'b0,1'b0,32'h00,1'b1,1'b1,1'b1,32'h0D,2'd1);
    vt[16] = mk(1'b0,1'b0,1'b0,32'h00,1'b0,1'b1,1'b0,32'h0D,2'd0);
    vt[17] = mk(1'b0,1'b0,1'b1,32'h11,1'b0,1'b1,1'b0,32'h0D,2'd0);
    vt[18] = mk(1'b0,1'b0,1'b1,32'h22,1'b1,1'b1,1'b1,32'h11,2'd1);
    vt[19] = mk(1'b0,1'b0,1'b0,32'h00,1'b0,1'b1,1'b1,32'h22,2'd1);
    vt[20] = mk(1'b0,1'b1,1'b1,32'h33,1'b1,1'b1,1'b1,32'h22,2'd1);
    vt[21] = mk(1'b0,1'b0,1'b0,32'h00,1'b0,1'b1,1'b0,32'h22,2'd0);
    vt[22] = mk(1'b0,1'b0,1'b1,32'h44,1'b0,1'b1,1'b0,32'h22,2'd0);
    vt[23] = mk(1'b1,1'b0,1'b1,32'h55,1'b0,1'b0,1'b1,32'h44,2'd1);
    vt[24] = mk(1'b0,1'b0,1'b0,32'h00,1'b0,1'b1,1'b0,32'h5A,2'd0);

    for (int i = 0; i < 25; i++) begin
      rst = vt[i].rst; flush = vt[i].flush; in_valid = vt[i].iv;
      in_data = vt[i].id; out_ready = vt[i].ordy;
      #2;
      chk($sformatf("vec%0d_in_ready", i), a_in_ready, vt[i].e_ir);
      chk($sformatf("vec%0d_out_valid", i), a_out_valid, vt[i].e_ov);
      chk($sformatf("vec%0d_out_data", i), a_out_data, vt[i].e_od);
      chk($sformatf("vec%0d_level", i), a_level, vt[i].e_lvl);
      tick();
    end

    // Pass-through instance: fill it, then refill while the head leaves.
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h6; out_ready = 1'b0;
    tick();
    in_data = 32'h7;
    #1;
    chk("b_blocked_in_ready", b_in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("b_pass_in_ready", b_in_ready, 1'b1);
    chk("b_pass_out_valid", b_out_valid, 1'b1);
    chk("b_pass_head", b_out_data, 32'h6);
    tick();
    chk("b_pass_next_data", b_out_data, 32'h7);
    chk("b_pass_next_valid", b_out_valid, 1'b1);
    chk("b_pass_level", b_level, 2'd1);
    in_valid = 1'b0;
    tick();

    // Randomized traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = $urandom_range(0, 3) != 0;
      in_data   = $urandom;
      out_ready = $urandom_range(0, 2) != 0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
